// File: rtl/shifter_operand_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : shifter_operand_stage_if
// Description : Handshake and data bundle for the shifter operand stage.
//               The upstream side carries the operand-2 request and the
//               downstream side carries the decoded barrel-shifter controls.
// Revision    : 1.0 - initial release
// ============================================================================
interface shifter_operand_stage_if;
    logic        in_valid;
    logic        in_ready;
    logic        in_imm;
    logic [11:0] in_op2;
    logic [31:0] in_rm;
    logic [7:0]  in_rs;
    logic        in_cflag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_value;
    logic [2:0]  out_mode;
    logic [4:0]  out_count;
    logic        out_ovr;
    logic [31:0] out_ovr_value;
    logic        out_carry;

    // Producer/consumer view (drives requests, consumes results)
    modport master (
        output in_valid, in_imm, in_op2, in_rm, in_rs, in_cflag, out_ready,
        input  in_ready, out_valid, out_value, out_mode, out_count,
               out_ovr, out_ovr_value, out_carry
    );

    // Stage view
    modport slave (
        input  in_valid, in_imm, in_op2, in_rm, in_rs, in_cflag, out_ready,
        output in_ready, out_valid, out_value, out_mode, out_count,
               out_ovr, out_ovr_value, out_carry
    );
endinterface
`default_nettype wire

// File: rtl/shifter_operand_stage.sv
`default_nettype none
// ============================================================================
// Module      : shifter_operand_stage
// Description : Decodes the ARM shifter-operand field into barrel shifter
//               value/mode/count, computes shifter carry-out, flags amounts a
//               5-bit count cannot express, and buffers results in a 2-entry
//               valid/ready FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module shifter_operand_stage #(
    parameter int DEPTH = 2
) (
    input wire logic               clk,
    input wire logic               rst,
    shifter_operand_stage_if.slave sif
);

    localparam logic [2:0] c_LSL   = 3'b000;
    localparam logic [2:0] c_LSR   = 3'b001;
    localparam logic [2:0] c_ASR   = 3'b011;
    localparam logic [2:0] c_ROR   = 3'b101;
    localparam logic [1:0] c_FULL  = 2'(DEPTH);
    localparam int         c_W     = 74;

    logic [7:0]     w_amt;
    logic [4:0]     w_n5;
    logic [1:0]     w_type;
    logic [4:0]     w_imm_cnt;
    logic [31:0]    w_imm_val;
    logic [31:0]    w_value;
    logic [2:0]     w_mode;
    logic [4:0]     w_count;
    logic           w_ovr;
    logic [31:0]    w_ovr_value;
    logic           w_carry;
    logic [c_W-1:0] w_entry;
    logic           w_push;
    logic           w_pop;

    logic [c_W-1:0] r_mem [DEPTH];
    logic           r_wptr;
    logic           r_rptr;
    logic [1:0]     r_count;

    assign w_type    = sif.in_op2[6:5];
    assign w_amt     = sif.in_op2[4] ? sif.in_rs : {3'b000, sif.in_op2[11:7]};
    assign w_n5      = w_amt[4:0];
    assign w_imm_cnt = {sif.in_op2[11:8], 1'b0};
    assign w_imm_val = {24'b0, sif.in_op2[7:0]};

    // Decode the operand-2 encoding into shifter controls, carry and overrides
    always_comb begin
        w_value     = sif.in_rm;
        w_mode      = c_LSL;
        w_count     = 5'd0;
        w_ovr       = 1'b0;
        w_ovr_value = 32'd0;
        w_carry     = sif.in_cflag;
        if (sif.in_imm) begin
            // Rotated immediate: carry is bit 31 of the rotated byte
            w_value = w_imm_val;
            w_mode  = c_ROR;
            w_count = w_imm_cnt;
            if (w_imm_cnt != 5'd0) begin
                w_carry = w_imm_val[w_imm_cnt - 5'd1];
            end
        end else if (w_amt == 8'd0) begin
            // Register-form zero amount is a plain pass-through; the
            // immediate form encodes LSR/ASR #32 and RRX here instead
            if (!sif.in_op2[4]) begin
                case (w_type)
                    2'b01: begin
                        w_ovr       = 1'b1;
                        w_ovr_value = 32'd0;
                        w_carry     = sif.in_rm[31];
                    end
                    2'b10: begin
                        w_ovr       = 1'b1;
                        w_ovr_value = {32{sif.in_rm[31]}};
                        w_carry     = sif.in_rm[31];
                    end
                    2'b11: begin
                        w_ovr       = 1'b1;
                        w_ovr_value = {sif.in_cflag, sif.in_rm[31:1]};
                        w_carry     = sif.in_rm[0];
                    end
                    default: begin
                        w_ovr = 1'b0;
                    end
                endcase
            end
        end else if (w_amt[7:5] == 3'd0) begin
            // Amount 1..31: the shifter handles it directly
            w_count = w_n5;
            case (w_type)
                2'b00:   w_mode = c_LSL;
                2'b01:   w_mode = c_LSR;
                2'b10:   w_mode = c_ASR;
                default: w_mode = c_ROR;
            endcase
            // 0 - n wraps to 32 - n for n in 1..31
            w_carry = (w_type == 2'b00) ? sif.in_rm[5'd0 - w_n5]
                                        : sif.in_rm[w_n5 - 5'd1];
        end else begin
            // Register amount of 32 or more
            case (w_type)
                2'b00: begin
                    w_ovr   = 1'b1;
                    w_carry = (w_amt == 8'd32) ? sif.in_rm[0] : 1'b0;
                end
                2'b01: begin
                    w_ovr   = 1'b1;
                    w_carry = (w_amt == 8'd32) ? sif.in_rm[31] : 1'b0;
                end
                2'b10: begin
                    w_ovr       = 1'b1;
                    w_ovr_value = {32{sif.in_rm[31]}};
                    w_carry     = sif.in_rm[31];
                end
                default: begin
                    // Rotation is modulo 32; n[4:0] = 0 wraps the index to
                    // bit 31, which is exactly the required carry
                    w_mode  = c_ROR;
                    w_count = w_n5;
                    w_carry = sif.in_rm[w_n5 - 5'd1];
                end
            endcase
        end
        // Overridden results feed the shifter as an identity LSL #0
        if (w_ovr) begin
            w_value = w_ovr_value;
            w_mode  = c_LSL;
            w_count = 5'd0;
        end
    end

    assign w_entry = {w_value, w_mode, w_count, w_ovr, w_ovr_value, w_carry};

    assign sif.in_ready  = (r_count != c_FULL) && !rst;
    assign sif.out_valid = (r_count != 2'd0);
    assign w_push        = sif.in_valid && sif.in_ready;
    assign w_pop         = sif.out_valid && sif.out_ready;

    assign {sif.out_value, sif.out_mode, sif.out_count, sif.out_ovr,
            sif.out_ovr_value, sif.out_carry} = r_mem[r_rptr];

    // FIFO storage, pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= w_entry;
                r_wptr        <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_shifter_operand_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_shifter_operand_stage
// Description : Directed, table-driven bench for shifter_operand_stage with
//               hand-written backpressure and reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shifter_operand_stage;

    typedef struct packed {
        logic        imm;
        logic [11:0] op2;
        logic [31:0] rm;
        logic [7:0]  rs;
        logic        cflag;
        logic [31:0] e_value;
        logic [2:0]  e_mode;
        logic [4:0]  e_count;
        logic        e_ovr;
        logic [31:0] e_ovrv;
        logic        e_carry;
    } vec_t;

    localparam int c_NV = 21;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    vec_t vecs [c_NV];

    shifter_operand_stage_if sif ();

    shifter_operand_stage #(.DEPTH(2)) dut (
        .clk (clk),
        .rst (rst),
        .sif (sif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Absolute time bound so the run always reaches an end
    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] outs();
        return {53'd0, sif.out_valid, sif.out_value, sif.out_mode, sif.out_count,
                sif.out_ovr, sif.out_ovr_value, sif.out_carry};
    endfunction

    function automatic logic [127:0] expv(input vec_t v);
        return {53'd0, 1'b1, v.e_value, v.e_mode, v.e_count, v.e_ovr, v.e_ovrv, v.e_carry};
    endfunction

    task automatic drive(input logic imm, input logic [11:0] op2, input logic [31:0] rm,
                         input logic [7:0] rs, input logic cflag);
        sif.in_imm   = imm;
        sif.in_op2   = op2;
        sif.in_rm    = rm;
        sif.in_rs    = rs;
        sif.in_cflag = cflag;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        //         imm  op2      rm            rs     cf   value         mode    cnt   ovr   ovr_value     carry
        vecs[0]  = '{1'b1, 12'h4FF, 32'h0,        8'd0,  1'b0, 32'hFF,       3'b101, 5'd8, 1'b0, 32'h0,        1'b1};
        vecs[1]  = '{1'b1, 12'h0FF, 32'h0,        8'd0,  1'b1, 32'hFF,       3'b101, 5'd0, 1'b0, 32'h0,        1'b1};
        vecs[2]  = '{1'b0, 12'h020, 32'h80000001, 8'd0,  1'b0, 32'h0,        3'b000, 5'd0, 1'b1, 32'h0,        1'b1};
        vecs[3]  = '{1'b0, 12'h040, 32'h80000001, 8'd0,  1'b0, 32'hFFFFFFFF, 3'b000, 5'd0, 1'b1, 32'hFFFFFFFF, 1'b1};
        vecs[4]  = '{1'b0, 12'h060, 32'h80000001, 8'd0,  1'b0, 32'h40000000, 3'b000, 5'd0, 1'b1, 32'h40000000, 1'b1};
        vecs[5]  = '{1'b0, 12'h010, 32'h1,        8'd32, 1'b0, 32'h0,        3'b000, 5'd0, 1'b1, 32'h0,        1'b1};
        vecs[6]  = '{1'b0, 12'h010, 32'h1,        8'd33, 1'b0, 32'h0,        3'b000, 5'd0, 1'b1, 32'h0,        1'b0};
        vecs[7]  = '{1'b0, 12'h070, 32'h1,        8'd0,  1'b1, 32'h1,        3'b000, 5'd0, 1'b0, 32'h0,        1'b1};
        vecs[8]  = '{1'b0, 12'h030, 32'h1,        8'd0,  1'b0, 32'h1,        3'b000, 5'd0, 1'b0, 32'h0,        1'b0};
        vecs[9]  = '{1'b0, 12'h070, 32'h80000000, 8'd64, 1'b0, 32'h80000000, 3'b101, 5'd0, 1'b0, 32'h0,        1'b1};
        vecs[10] = '{1'b0, 12'h200, 32'h10000000, 8'd0,  1'b0, 32'h10000000, 3'b000, 5'd4, 1'b0, 32'h0,        1'b1};
        vecs[11] = '{1'b0, 12'h0C0, 32'h3,        8'd0,  1'b0, 32'h3,        3'b011, 5'd1, 1'b0, 32'h0,        1'b1};
        vecs[12] = '{1'b0, 12'h070, 32'h80,       8'd8,  1'b0, 32'h80,       3'b101, 5'd8, 1'b0, 32'h0,        1'b1};
        vecs[13] = '{1'b0, 12'h030, 32'h80000000, 8'd32, 1'b0, 32'h0,        3'b000, 5'd0, 1'b1, 32'h0,        1'b1};
        vecs[14] = '{1'b0, 12'h050, 32'h80000000, 8'd40, 1'b0, 32'hFFFFFFFF, 3'b000, 5'd0, 1'b1, 32'hFFFFFFFF, 1'b1};
        vecs[15] = '{1'b0, 12'h000, 32'h5,        8'd0,  1'b1, 32'h5,        3'b000, 5'd0, 1'b0, 32'h0,        1'b1};
        vecs[16] = '{1'b0, 12'h070, 32'h8,        8'd36, 1'b0, 32'h8,        3'b101, 5'd4, 1'b0, 32'h0,        1'b1};
        vecs[17] = '{1'b0, 12'h030, 32'h80000000, 8'd33, 1'b1, 32'h0,        3'b000, 5'd0, 1'b1, 32'h0,        1'b0};
        vecs[18] = '{1'b0, 12'h0A0, 32'h2,        8'd0,  1'b1, 32'h2,        3'b001, 5'd1, 1'b0, 32'h0,        1'b0};
        vecs[19] = '{1'b1, 12'h102, 32'h0,        8'd0,  1'b0, 32'h2,        3'b101, 5'd2, 1'b0, 32'h0,        1'b1};
        vecs[20] = '{1'b0, 12'h090, 32'h10000000, 8'd4,  1'b0, 32'h10000000, 3'b000, 5'd4, 1'b0, 32'h0,        1'b1};

        // Reset state
        rst           = 1'b1;
        sif.in_valid  = 1'b0;
        sif.out_ready = 1'b0;
        drive(1'b0, 12'h0, 32'h0, 8'h0, 1'b0);
        tick();
        tick();
        check("reset_in_ready", {127'd0, sif.in_ready}, 128'd0);
        check("reset_outputs", outs(), 128'd0);
        rst = 1'b0;
        tick();
        check("post_reset_in_ready", {127'd0, sif.in_ready}, 128'd1);

        // Decode table: push one, check head next cycle, then pop it
        for (int i = 0; i < c_NV; i++) begin
            drive(vecs[i].imm, vecs[i].op2, vecs[i].rm, vecs[i].rs, vecs[i].cflag);
            sif.in_valid  = 1'b1;
            sif.out_ready = 1'b0;
            tick();
            check($sformatf("vec%0d", i), outs(), expv(vecs[i]));
            sif.in_valid  = 1'b0;
            sif.out_ready = 1'b1;
            tick();
            check($sformatf("vec%0d_drain", i), {127'd0, sif.out_valid}, 128'd0);
        end

        // Backpressure: three pass-through operands A, B, C with the consumer stalled
        sif.out_ready = 1'b0;
        sif.in_valid  = 1'b1;
        drive(1'b0, 12'h000, 32'hAAAA0001, 8'd0, 1'b0);
        tick();
        check("bp_ready_after_1", {127'd0, sif.in_ready}, 128'd1);
        check("bp_head_a", {96'd0, sif.out_value}, {96'd0, 32'hAAAA0001});
        drive(1'b0, 12'h000, 32'hBBBB0002, 8'd0, 1'b0);
        tick();
        check("bp_ready_after_2", {127'd0, sif.in_ready}, 128'd0);
        check("bp_head_a_stable", {96'd0, sif.out_value}, {96'd0, 32'hAAAA0001});
        drive(1'b0, 12'h000, 32'hCCCC0003, 8'd0, 1'b0);
        tick();
        check("bp_c_refused", {127'd0, sif.in_ready}, 128'd0);
        check("bp_head_a_held", {96'd0, sif.out_value}, {96'd0, 32'hAAAA0001});
        // Release: A pops while C is still refused (full at that edge)
        sif.out_ready = 1'b1;
        tick();
        check("bp_head_b", {96'd0, sif.out_value}, {96'd0, 32'hBBBB0002});
        check("bp_ready_returns", {127'd0, sif.in_ready}, 128'd1);
        // Pop B and push C in the same cycle at occupancy 1
        tick();
        check("bp_head_c", {95'd0, sif.out_valid, sif.out_value}, {95'd0, 1'b1, 32'hCCCC0003});
        check("bp_ready_occ1", {127'd0, sif.in_ready}, 128'd1);
        sif.in_valid = 1'b0;
        tick();
        check("bp_empty", {127'd0, sif.out_valid}, 128'd0);

        // Reset mid-stream with two entries queued and a third presented
        sif.out_ready = 1'b0;
        sif.in_valid  = 1'b1;
        drive(1'b0, 12'h000, 32'h11111111, 8'd0, 1'b1);
        tick();
        drive(1'b0, 12'h000, 32'h22222222, 8'd0, 1'b1);
        tick();
        check("mid_full", {127'd0, sif.in_ready}, 128'd0);
        rst = 1'b1;
        drive(1'b0, 12'h000, 32'h33333333, 8'd0, 1'b1);
        tick();
        check("mid_rst_outputs", outs(), 128'd0);
        check("mid_rst_in_ready", {127'd0, sif.in_ready}, 128'd0);
        rst          = 1'b0;
        sif.in_valid = 1'b0;
        tick();
        check("mid_after_ready", {127'd0, sif.in_ready}, 128'd1);
        check("mid_after_empty", outs(), 128'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
